// File: rtl/cart_loader.sv
// Cartridge image loader: streams an ioctl download into ROM, sizes it,
// resolves the bank-switch scheme and SuperChip flag, then holds the
// 2600 core in reset for a programmable number of cycles.
module cart_loader #(
  parameter int HOLD_CYCLES = 16,
  parameter int MAX_SIZE    = 32768
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [31:0] ioctl_file_ext,
  input  logic [1:0]  sc_mode,
  output logic        rom_we,
  output logic [14:0] rom_waddr,
  output logic [7:0]  rom_wdata,
  output logic        core_reset,
  output logic [3:0]  force_bs,
  output logic        sc,
  output logic [16:0] rom_size,
  output logic        load_done,
  output logic        load_err
);

  localparam int          CNT_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [24:0] MAX_ADDR = 25'(MAX_SIZE);
  localparam int          N_EXT    = 9;

  // Extension table; the scheme code of entry i is i+1.
  localparam logic [23:0] EXT_TABLE [N_EXT] = '{
    ".F8", ".F6", ".FE", ".E0", ".3F", ".F4", ".P2", ".FA", ".CV"
  };

  typedef enum logic [1:0] {IDLE, LOAD, RESOLVE, HOLD} state_t;

  state_t             state_reg, state_next;
  logic               dl_prev_reg;
  logic               dl_rise, dl_fall;
  logic [CNT_W-1:0]   hold_cnt_reg;
  logic [16:0]        size_acc_reg;
  logic [7:0]         filler_reg;
  logic               cand_reg;
  logic               load_err_reg;
  logic               load_done_reg;
  logic               core_reset_reg;
  logic [3:0]         force_bs_reg;
  logic               sc_reg;
  logic [16:0]        rom_size_reg;

  logic               wr_in_load;
  logic               addr_ok;
  logic               load_start;
  logic [17:0]        addr_p1;
  logic [16:0]        size_cand;
  logic [23:0]        ext_sel;
  logic [N_EXT-1:0]   ext_hit;
  logic [3:0]         bs_ext;
  logic               ext_match;
  logic [3:0]         bs_size;
  logic [3:0]         bs_resolved;
  logic               sc_resolved;

  assign dl_rise = ioctl_download & ~dl_prev_reg;
  assign dl_fall = ~ioctl_download & dl_prev_reg;

  // State register
  always_ff @(posedge clk_sys) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic; a new download aborts the hold phase
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (dl_rise) state_next = LOAD;
      LOAD:    if (dl_fall) state_next = RESOLVE;
      RESOLVE: state_next = HOLD;
      HOLD: begin
        if (dl_rise)                 state_next = LOAD;
        else if (hold_cnt_reg == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode: ROM write pass-through and write qualification
  always_comb begin
    wr_in_load = (state_reg == LOAD) && ioctl_wr;
    addr_ok    = ioctl_addr < MAX_ADDR;
    rom_we     = wr_in_load && addr_ok && !reset;
    load_start = (state_reg != LOAD) && (state_next == LOAD);
    addr_p1    = {1'b0, ioctl_addr[16:0]} + 18'd1;
    size_cand  = addr_p1[17] ? 17'h1FFFF : addr_p1[16:0];
  end

  assign rom_waddr = ioctl_addr[14:0];
  assign rom_wdata = ioctl_dout;

  // A dot in the second byte means a two-character extension sits right-aligned
  assign ext_sel = (ioctl_file_ext[23:16] == 8'h2E) ? ioctl_file_ext[23:0]
                                                    : ioctl_file_ext[31:8];

  genvar gi;
  generate
    for (gi = 0; gi < N_EXT; gi++) begin : g_ext
      assign ext_hit[gi] = (ext_sel == EXT_TABLE[gi]);
    end
  endgenerate

  // Extension lookup; scanning downward leaves the first table match in place
  always_comb begin
    bs_ext    = 4'd0;
    ext_match = 1'b0;
    for (int i = N_EXT - 1; i >= 0; i--) begin
      if (ext_hit[i]) begin
        bs_ext    = 4'(i + 1);
        ext_match = 1'b1;
      end
    end
  end

  // Size-based scheme guess and SuperChip policy
  always_comb begin
    if (size_acc_reg <= 17'd4096)       bs_size = 4'd0;
    else if (size_acc_reg == 17'd8192)  bs_size = 4'd1;
    else if (size_acc_reg == 17'd12288) bs_size = 4'd8;
    else if (size_acc_reg == 17'd16384) bs_size = 4'd2;
    else if (size_acc_reg == 17'd32768) bs_size = 4'd6;
    else                                bs_size = 4'd0;

    bs_resolved = ext_match ? bs_ext : bs_size;

    case (sc_mode)
      2'd1:    sc_resolved = 1'b0;
      2'd2:    sc_resolved = 1'b1;
      default: sc_resolved = (ioctl_file_ext[7:0] == "S") ||
                             (cand_reg && (size_acc_reg >= 17'd8192));
    endcase
  end

  // Download edge tracker; sampled during reset so a held download is not replayed
  always_ff @(posedge clk_sys) begin
    dl_prev_reg <= ioctl_download;
  end

  // Load bookkeeping: size, overflow flag and SuperChip candidate detection
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      size_acc_reg <= '0;
      filler_reg   <= '0;
      cand_reg     <= 1'b0;
      load_err_reg <= 1'b0;
    end else if (load_start) begin
      size_acc_reg <= '0;
      filler_reg   <= '0;
      cand_reg     <= 1'b0;
      load_err_reg <= 1'b0;
    end else if (wr_in_load) begin
      if (!addr_ok) load_err_reg <= 1'b1;
      if (size_cand > size_acc_reg) size_acc_reg <= size_cand;
      if (ioctl_addr == '0) begin
        filler_reg <= ioctl_dout;
        cand_reg   <= 1'b1;
      end else if ((ioctl_addr[11:8] == 4'd0) && (ioctl_dout != filler_reg)) begin
        cand_reg <= 1'b0;
      end
    end
  end

  // Resolved outputs update only in RESOLVE and persist afterwards
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      force_bs_reg <= '0;
      sc_reg       <= 1'b0;
      rom_size_reg <= '0;
    end else if (state_reg == RESOLVE) begin
      force_bs_reg <= bs_resolved;
      sc_reg       <= sc_resolved;
      rom_size_reg <= size_acc_reg;
    end
  end

  // Hold counter, core reset and completion pulse
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hold_cnt_reg   <= '0;
      core_reset_reg <= 1'b1;
      load_done_reg  <= 1'b0;
    end else begin
      if (state_reg == RESOLVE)
        hold_cnt_reg <= CNT_W'(HOLD_CYCLES - 1);
      else if ((state_reg == HOLD) && (hold_cnt_reg != '0))
        hold_cnt_reg <= hold_cnt_reg - CNT_W'(1);
      core_reset_reg <= (state_next != IDLE);
      load_done_reg  <= (state_reg == HOLD) && (state_next == IDLE);
    end
  end

  assign core_reset = core_reset_reg;
  assign load_done  = load_done_reg;
  assign load_err   = load_err_reg;
  assign force_bs   = force_bs_reg;
  assign sc         = sc_reg;
  assign rom_size   = rom_size_reg;

endmodule

// File: tb/tb_cart_loader.sv
// Directed bench for cart_loader: table of complete downloads plus
// hand-written sequences for hold abort and reset during a load.
module tb_cart_loader;

  localparam int H   = 16;
  localparam int MAX = 32768;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [31:0] ioctl_file_ext;
  logic [1:0]  sc_mode;
  logic        rom_we;
  logic [14:0] rom_waddr;
  logic [7:0]  rom_wdata;
  logic        core_reset;
  logic [3:0]  force_bs;
  logic        sc;
  logic [16:0] rom_size;
  logic        load_done;
  logic        load_err;

  int n_checks = 0;
  int n_fail   = 0;

  cart_loader #(.HOLD_CYCLES(H), .MAX_SIZE(MAX)) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_file_ext (ioctl_file_ext),
    .sc_mode        (sc_mode),
    .rom_we         (rom_we),
    .rom_waddr      (rom_waddr),
    .rom_wdata      (rom_wdata),
    .core_reset     (core_reset),
    .force_bs       (force_bs),
    .sc             (sc),
    .rom_size       (rom_size),
    .load_done      (load_done),
    .load_err       (load_err)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [31:0] ext;
    logic [1:0]  scm;
    int          size;
    int          pat;
    logic [3:0]  bs;
    logic        sc;
    logic        err;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // 0: varied bytes; 1: 0xFF wherever addr[11:8]==0; 2: all 0xFF but 0x1080; 3: all 0xFF
  function automatic logic [7:0] img_byte(input int a, input int pat);
    logic [7:0] b;
    b = 8'(a * 7 + 3);
    case (pat)
      1:       if (a[11:8] == 4'd0) b = 8'hFF;
      2:       b = (a == 32'h1080) ? 8'h00 : 8'hFF;
      3:       b = 8'hFF;
      default: ;
    endcase
    return b;
  endfunction

  task automatic do_write(input logic [24:0] a, input logic [7:0] d, input logic exp_we);
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
    #1;
    check("rom_we", 32'(rom_we), 32'(exp_we));
    if (exp_we) begin
      check("rom_waddr", 32'(rom_waddr), 32'(a[14:0]));
      check("rom_wdata", 32'(rom_wdata), 32'(d));
    end
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
  endtask

  // Sparse image: all filler-relevant bytes, every 16th byte, and the last byte
  task automatic write_image(input int size, input int pat);
    for (int a = 0; a < size; a++) begin
      if ((a < 256) || (a >= 'h1000 && a < 'h1100) || (a % 16 == 0) || (a == size - 1))
        do_write(25'(a), img_byte(a, pat), (a < MAX) ? 1'b1 : 1'b0);
    end
  endtask

  task automatic start_load(input logic [31:0] ext, input logic [1:0] scm);
    ioctl_file_ext = ext; sc_mode = scm; ioctl_download = 1'b1;
    tick();
    check("core_reset_rise", 32'(core_reset), 32'd1);
  endtask

  // Latency is counted in edges after the one that samples the falling edge
  task automatic finish_load(input string tag, input logic [3:0] ebs, input logic esc,
                             input int esize, input logic eerr);
    int  n;
    bit  seen;
    ioctl_download = 1'b0;
    tick();
    n = 0; seen = 0;
    while (!seen && n < 200) begin
      tick();
      n++;
      if (load_done) seen = 1;
    end
    check("load_done_latency", 32'(n), 32'(H + 1));
    check("force_bs", 32'(force_bs), 32'(ebs));
    check("sc", 32'(sc), 32'(esc));
    check("rom_size", 32'(rom_size), 32'(esize));
    check("load_err", 32'(load_err), 32'(eerr));
    check("core_reset_release", 32'(core_reset), 32'd0);
    tick();
    check("load_done_pulse", 32'(load_done), 32'd0);
    $display("%s: force_bs=%0d sc=%0d rom_size=%0d load_err=%0d latency=%0d",
             tag, force_bs, sc, rom_size, load_err, n);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0;
    ioctl_dout = '0; ioctl_file_ext = '0; sc_mode = '0;

    vecs[0]  = '{".BIN",           2'd0, 4096,  0, 4'd0, 1'b0, 1'b0};
    vecs[1]  = '{{".F8", 8'h00},   2'd0, 8192,  1, 4'd1, 1'b1, 1'b0};
    vecs[2]  = '{".BIN",           2'd0, 16384, 2, 4'd2, 1'b0, 1'b0};
    vecs[3]  = '{".BIN",           2'd0, 16384, 3, 4'd2, 1'b1, 1'b0};
    vecs[4]  = '{".BIN",           2'd0, 40000, 0, 4'd0, 1'b0, 1'b1};
    vecs[5]  = '{".BIN",           2'd0, 12288, 0, 4'd8, 1'b0, 1'b0};
    vecs[6]  = '{".BIN",           2'd0, 32768, 0, 4'd6, 1'b0, 1'b0};
    vecs[7]  = '{".BIN",           2'd2, 2048,  0, 4'd0, 1'b1, 1'b0};
    vecs[8]  = '{".F8S",           2'd0, 8192,  0, 4'd1, 1'b1, 1'b0};
    vecs[9]  = '{".F8S",           2'd1, 8192,  1, 4'd1, 1'b0, 1'b0};
    vecs[10] = '{{".CV", 8'h00},   2'd0, 2048,  0, 4'd9, 1'b0, 1'b0};
    vecs[11] = '{{".E0", 8'h00},   2'd3, 8192,  1, 4'd4, 1'b1, 1'b0};
    vecs[12] = '{{".FA", 8'h00},   2'd0, 4096,  1, 4'd8, 1'b0, 1'b0};
    vecs[13] = '{"x.3F",           2'd0, 4096,  0, 4'd5, 1'b0, 1'b0};
    vecs[14] = '{".BIN",           2'd0, 6000,  0, 4'd0, 1'b0, 1'b0};

    // Reset state
    tick(); tick();
    check("rst_force_bs", 32'(force_bs), 32'd0);
    check("rst_sc", 32'(sc), 32'd0);
    check("rst_rom_size", 32'(rom_size), 32'd0);
    check("rst_load_err", 32'(load_err), 32'd0);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_core_reset", 32'(core_reset), 32'd1);
    ioctl_wr = 1'b1; ioctl_addr = 25'd5;
    #1;
    check("rst_rom_we", 32'(rom_we), 32'd0);
    ioctl_wr = 1'b0;
    reset = 1'b0;
    tick();
    check("idle_core_reset", 32'(core_reset), 32'd0);
    $display("reset: core_reset released, outputs cleared");

    // Writes outside a download are ignored
    ioctl_wr = 1'b1; ioctl_addr = 25'd3; ioctl_dout = 8'h55;
    #1;
    check("idle_rom_we", 32'(rom_we), 32'd0);
    tick();
    ioctl_wr = 1'b0;
    $display("idle write: rom_we=%0d", rom_we);

    // Table of complete downloads
    foreach (vecs[i]) begin
      start_load(vecs[i].ext, vecs[i].scm);
      write_image(vecs[i].size, vecs[i].pat);
      finish_load($sformatf("vec%0d size=%0d", i, vecs[i].size),
                  vecs[i].bs, vecs[i].sc, vecs[i].size, vecs[i].err);
    end

    // Second download aborts HOLD three cycles in
    start_load({".F8", 8'h00}, 2'd0);
    write_image(8192, 1);
    ioctl_download = 1'b0;
    tick();
    tick();
    check("hold_force_bs", 32'(force_bs), 32'd1);
    check("hold_sc", 32'(sc), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("hold_load_done", 32'(load_done), 32'd0);
      check("hold_core_reset", 32'(core_reset), 32'd1);
    end
    start_load(".BIN", 2'd0);
    check("abort_load_done", 32'(load_done), 32'd0);
    write_image(4096, 0);
    finish_load("hold abort reload", 4'd0, 1'b0, 4096, 1'b0);

    // Reset in the middle of a load
    start_load({".F8", 8'h00}, 2'd0);
    for (int a = 0; a < 10; a++) do_write(25'(a), 8'hFF, 1'b1);
    reset = 1'b1;
    ioctl_wr = 1'b1; ioctl_addr = 25'd10;
    #1;
    check("midload_rst_rom_we", 32'(rom_we), 32'd0);
    tick();
    ioctl_wr = 1'b0;
    check("midload_rst_core_reset", 32'(core_reset), 32'd1);
    reset = 1'b0;
    for (int a = 11; a < 31; a++) do_write(25'(a), 8'hFF, 1'b0);
    ioctl_download = 1'b0;
    for (int k = 0; k < H + 10; k++) begin
      tick();
      check("postrst_load_done", 32'(load_done), 32'd0);
    end
    check("postrst_core_reset", 32'(core_reset), 32'd0);
    check("postrst_rom_size", 32'(rom_size), 32'd0);
    check("postrst_force_bs", 32'(force_bs), 32'd0);
    $display("reset mid-load: rom_size=%0d force_bs=%0d core_reset=%0d", rom_size, force_bs, core_reset);
    start_load({".F8", 8'h00}, 2'd0);
    write_image(4096, 1);
    finish_load("load after reset", 4'd1, 1'b0, 4096, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
